// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - FP op sequencer: fixed-latency launch, stall, capture, writeback pulse
// Optional FPU_STALL_CNT_EN adds a free-running stall cycle counter output.
module fpu_issue_ctrl #(
    parameter int unsigned LAT_ADD  = 2,
    parameter int unsigned LAT_MUL  = 2,
    parameter int unsigned LAT_DIV  = 6,
    parameter int unsigned LAT_SQRT = 8,
    parameter int unsigned LAT_CVT  = 1,
    parameter int unsigned LAT_CMP  = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [3:0]  fpucontrol,
    input  logic        fregwb_in,
    input  logic [4:0]  rd_in,
    input  logic        flush,
    input  logic [31:0] fpu_y,
    output logic        fpu_en,
    output logic [3:0]  fpu_op,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_fregwb,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
`ifdef FPU_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_op;
    logic        r_fregwb;
    logic [4:0]  r_rd;
    logic [31:0] r_data;
    logic        w_wait;
    logic        w_accept;

    function automatic logic [3:0] f_lat(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001:          f_lat = 4'(LAT_ADD);
            4'b0010:                   f_lat = 4'(LAT_MUL);
            4'b0011:                   f_lat = 4'(LAT_DIV);
            4'b0100:                   f_lat = 4'(LAT_SQRT);
            4'b0101, 4'b1001:          f_lat = 4'(LAT_CVT);
            4'b0110, 4'b0111, 4'b1000: f_lat = 4'(LAT_CMP);
            default:                   f_lat = 4'd1;
        endcase
    endfunction

    assign w_wait   = (r_state == WAIT);
    assign w_accept = start && !flush && (r_state == IDLE || r_state == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_op     <= 4'd0;
            r_fregwb <= 1'b0;
            r_rd     <= 5'd0;
            r_data   <= 32'd0;
        end else if (flush) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else if (w_accept) begin
            r_op     <= fpucontrol;
            r_fregwb <= fregwb_in;
            r_rd     <= rd_in;
            r_cnt    <= f_lat(fpucontrol);
            r_state  <= WAIT;
        end else begin
            case (r_state)
                WAIT: begin
                    // Last datapath cycle: the result on fpu_y is final now.
                    if (r_cnt == 4'd1) begin
                        r_data  <= fpu_y;
                        r_cnt   <= 4'd0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fpu_en    = w_wait;
    assign fpu_op    = r_op;
    assign stall     = w_accept | w_wait;
    assign wb_valid  = (r_state == DONE);
    assign wb_fregwb = r_fregwb;
    assign wb_rd     = r_rd;
    assign wb_data   = r_data;

`ifdef FPU_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= 32'd0;
        end else if (stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - directed and random checks of fpu_issue_ctrl against a timing model
module tb_fpu_issue_ctrl;
    logic        clk;
    logic        rstn;
    logic        start;
    logic [3:0]  fpucontrol;
    logic        fregwb_in;
    logic [4:0]  rd_in;
    logic        flush;
    logic [31:0] fpu_y;
    logic        fpu_en;
    logic [3:0]  fpu_op;
    logic        stall;
    logic        wb_valid;
    logic        wb_fregwb;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`ifdef FPU_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    fpu_issue_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .fpucontrol (fpucontrol),
        .fregwb_in  (fregwb_in),
        .rd_in      (rd_in),
        .flush      (flush),
        .fpu_y      (fpu_y),
        .fpu_en     (fpu_en),
        .fpu_op     (fpu_op),
        .stall      (stall),
        .wb_valid   (wb_valid),
        .wb_fregwb  (wb_fregwb),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data)
`ifdef FPU_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;

    // Model: an accepted op occupies L busy cycles starting at the accept edge,
    // then one writeback cycle; result is the fpu_y seen in the last busy cycle.
    int          lat_tbl [16];
    int          cyc;
    bit          m_active;
    int          m_a;
    int          m_l;
    logic [3:0]  m_op;
    logic        m_fw;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [31:0] m_scnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_op     = 4'd0;
        m_fw     = 1'b0;
        m_rd     = 5'd0;
        m_data   = 32'd0;
        m_scnt   = 32'd0;
    endtask

    task automatic step(input logic s, input logic [3:0] op, input logic fw,
                        input logic [4:0] rd, input logic fl, input logic [31:0] y);
        bit busy, done, acc;
        @(negedge clk);
        start = s; fpucontrol = op; fregwb_in = fw; rd_in = rd; flush = fl; fpu_y = y;
        #1;
        busy = m_active && cyc >= m_a && cyc < m_a + m_l;
        done = m_active && cyc == m_a + m_l;
        acc  = s && !fl && !busy;
        check("fpu_en",    {31'd0, fpu_en},    {31'd0, busy});
        check("fpu_op",    {28'd0, fpu_op},    {28'd0, m_op});
        check("stall",     {31'd0, stall},     {31'd0, busy | acc});
        check("wb_valid",  {31'd0, wb_valid},  {31'd0, done});
        check("wb_fregwb", {31'd0, wb_fregwb}, {31'd0, m_fw});
        check("wb_rd",     {27'd0, wb_rd},     {27'd0, m_rd});
        check("wb_data",   wb_data,            m_data);
`ifdef FPU_STALL_CNT_EN
        check("stall_cnt", stall_cnt,          m_scnt);
`endif
        if (busy | acc) m_scnt = m_scnt + 32'd1;
        if (fl) begin
            m_active = 0;
        end else begin
            if (busy && cyc == m_a + m_l - 1) m_data = y;
            if (acc) begin
                m_active = 1;
                m_a  = cyc + 1;
                m_l  = lat_tbl[op];
                m_op = op; m_fw = fw; m_rd = rd;
            end else if (done) begin
                m_active = 0;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'($urandom), 1'b0, 5'($urandom), 1'b0, $urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check("rst_fpu_en",   {31'd0, fpu_en},    32'd0);
        check("rst_fpu_op",   {28'd0, fpu_op},    32'd0);
        check("rst_stall",    {31'd0, stall},     32'd0);
        check("rst_wb_valid", {31'd0, wb_valid},  32'd0);
        check("rst_wb_fregwb",{31'd0, wb_fregwb}, 32'd0);
        check("rst_wb_rd",    {27'd0, wb_rd},     32'd0);
        check("rst_wb_data",  wb_data,            32'd0);
`ifdef FPU_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt,         32'd0);
`endif
        @(negedge clk);
        rstn = 1'b1;
        cyc += 2;
    endtask

    initial begin
        lat_tbl = '{2, 2, 2, 6, 8, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        cyc = 0;
        rstn = 1'b1; start = 1'b0; fpucontrol = 4'd0; fregwb_in = 1'b0;
        rd_in = 5'd0; flush = 1'b0; fpu_y = 32'd0;
        model_reset();
        do_reset();

        // fadd, rd=5, result 1.0
        step(1'b1, 4'b0000, 1'b0, 5'd5, 1'b0, 32'h3F80_0000);
        for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 32'h3F80_0000);

        // fsqrt, 8 busy cycles
        step(1'b1, 4'b0100, 1'b0, 5'd7, 1'b0, $urandom);
        idle(11);

        // feq then fmul back-to-back with start held through the busy cycle
        step(1'b1, 4'b0110, 1'b1, 5'd10, 1'b0, $urandom);
        step(1'b1, 4'b0110, 1'b1, 5'd10, 1'b0, $urandom);
        step(1'b1, 4'b0010, 1'b0, 5'd11, 1'b0, $urandom);
        idle(5);

        // fdiv flushed in its third busy cycle, then start+flush from idle
        step(1'b1, 4'b0011, 1'b0, 5'd3, 1'b0, $urandom);
        idle(2);
        step(1'b0, 4'd0, 1'b0, 5'd0, 1'b1, $urandom);
        idle(8);
        step(1'b1, 4'b0001, 1'b1, 5'd9, 1'b1, $urandom);
        idle(4);

        // illegal op: single busy cycle
        step(1'b1, 4'b1111, 1'b1, 5'd31, 1'b0, $urandom);
        idle(4);

        // reset while fdiv is busy
        step(1'b1, 4'b0011, 1'b1, 5'd20, 1'b0, $urandom);
        idle(2);
        do_reset();
        idle(8);

        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom), 5'($urandom),
                 ($urandom_range(0, 15) == 0), $urandom);
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Sequencer directly downstream of the FP instruction decoder. It consumes the 4-bit FPU op code and the writeback-select bit, then launches the op into the FPU datapath.
- Each op class has a fixed latency. The block holds the op stable for that many cycles, stalls the integer pipeline meanwhile, captures the FPU result, and emits a one-cycle writeback pulse.
- A flush cancels an in-flight op without writeback.

Parameters:
- LAT_ADD, 2, cycles for fadd/fsub (op 0000, 0001)
- LAT_MUL, 2, cycles for fmul (op 0010)
- LAT_DIV, 6, cycles for fdiv (op 0011)
- LAT_SQRT, 8, cycles for fsqrt (op 0100)
- LAT_CVT, 1, cycles for ftoi/itof (op 0101, 1001)
- LAT_CMP, 1, cycles for feq/flt/fle (op 0110, 0111, 1000)
- All latencies are in the range 1..15 (4-bit counter).

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  FP op present in EX this cycle
- fpucontrol  in  4  op code from decoder
- fregwb_in  in  1  1 = result goes to integer regfile (cmp, ftoi); 0 = FP regfile
- rd_in  in  5  destination register
- flush  in  1  cancel in-flight op
- fpu_y  in  32  result bus from FPU datapath
- fpu_en  out  1  op active in datapath
- fpu_op  out  4  latched op code driven to datapath
- stall  out  1  freeze upstream pipeline
- wb_valid  out  1  one-cycle writeback pulse
- wb_fregwb  out  1  latched fregwb_in
- wb_rd  out  5  latched rd_in
- wb_data  out  32  captured result

Behaviour:
- Reset: async on rstn=0. State=IDLE, cnt=0, fpu_en=0, fpu_op=0000, stall=0, wb_valid=0, wb_fregwb=0, wb_rd=0, wb_data=0.
- States are IDLE, WAIT and DONE.
- Accept: in IDLE or DONE with start=1 and flush=0:
  - latch fpucontrol, fregwb_in and rd_in;
  - cnt <= LAT(op); next state is WAIT.
- Op codes 1010..1111 are illegal and use latency 1, with result captured as-is.
- WAIT:
  - fpu_en=1 and fpu_op=latched op; fpu_op is stable for the whole WAIT.
  - cnt decrements each cycle.
  - When cnt==1: wb_data <= fpu_y; next state is DONE.
- Latency: start accepted at edge T. WAIT occupies T+1..T+L, capture happens at edge T+L, DONE at cycle T+L+1.
- DONE:
  - wb_valid=1 for exactly one cycle; wb_rd and wb_fregwb are valid alongside it.
  - Next state is IDLE, or WAIT if start=1 (back-to-back, no bubble).
- stall = (start & (IDLE|DONE) & ~flush) | WAIT. It is combinational, and low in DONE unless a new op is accepted.
- wb_data, wb_rd and wb_fregwb hold their values until the next capture or accept.
- Flush:
  - In any state, flush=1 at an edge forces IDLE and clears cnt and fpu_en.
  - No wb_valid follows. A wb_valid already asserted in DONE still completes that cycle.
  - flush overrides a simultaneous start.
- start while in WAIT is ignored; the upstream pipeline is stalled, so it reasserts start later.
- rstn deasserted mid-op: immediate IDLE, no writeback.

Optional Feature:
- Macro FPU_STALL_CNT_EN.
- Defined:
  - adds output port stall_cnt [31:0];
  - increments on every cycle stall=1, wraps at 2^32-1 to 0;
  - reset to 0 by rstn.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset: rstn=0 mid-WAIT (fdiv op 0011) -> all outputs 0 immediately, no wb_valid after release.
- fadd: start=1, fpucontrol=0000, rd=5, fregwb=0, fpu_y=0x3F800000 -> stall high 3 cycles (accept + 2 WAIT), wb_valid at cycle T+3 with wb_rd=5, wb_data=0x3F800000, wb_fregwb=0.
- fsqrt: op 0100 with LAT_SQRT=8 -> fpu_en high 8 cycles, fpu_op=0100 constant, single wb_valid at T+9.
- Back-to-back: feq (0110, fregwb=1, rd=10) then fmul (0010) with start held -> first wb_valid in DONE with stall=1 for the new accept, second wb_valid 3 cycles later, no idle bubble.
- Flush: fdiv start, flush=1 at WAIT cycle 3 -> IDLE next cycle, no wb_valid, stall=0. Also start=1 and flush=1 together from IDLE -> no accept.
- Illegal op 1111 -> latency 1, wb_valid at T+2. With FPU_STALL_CNT_EN defined, stall_cnt counts exactly 2 for this op.
